// File: rtl/fetch_unit.sv
// RISC-V fetch stage: PC, one-outstanding imem request, one-entry decode buffer, branch redirect/flush.
// Latency: response in cycle c+k gives instr_valid from c+k+1; decode backpressure holds the buffer and stops new requests.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    input  logic [31:0] imm_ext,
    output logic        fetch_err
);

    localparam logic [1:0] REQ  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        discard;
    logic [31:0] target;
    logic        redirect;
    logic        misaligned;
    logic        req_hs;

    assign target     = branch_pc + imm_ext;
    assign redirect   = branch_taken && (state != HALT);
    assign misaligned = (target[1:0] != 2'b00);

    // State already reads REQ during reset, so the request is masked until reset drops.
    assign imem_req_valid = (state == REQ) && !reset;
    assign imem_req_addr  = pc;
    assign instr_valid    = (state == HOLD);
    assign fetch_err      = (state == HALT);
    assign req_hs         = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= REQ;
            pc       <= RESET_PC;
            discard  <= 1'b0;
            instr    <= 32'h0;
            instr_pc <= 32'h0;
        end else if (redirect && misaligned) begin
            state <= HALT;
        end else if (redirect) begin
            pc <= target;
            case (state)
                REQ: begin
                    // The fetch just accepted targets the old PC; drop its response later.
                    if (req_hs) begin
                        state   <= WAIT;
                        discard <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state   <= REQ;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                HOLD:    state <= REQ;
                default: state <= state;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (req_hs)
                        state <= WAIT;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            instr    <= imem_rsp_data;
                            instr_pc <= pc;
                            pc       <= pc + 32'd4;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready)
                        state <= REQ;
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core. It holds the program counter, issues word fetches to instruction memory over a valid/ready request port, and buffers one fetched instruction for decode. Decode feeds the immediate extender with instr[31:7]. The block computes branch targets as branch_pc + imm_ext, using the extender's sign-extended B-type immediate, and flushes wrong-path fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- imem_req_valid  out  1  fetch request pending.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address; equals the current PC.
- imem_rsp_valid  in  1  response data valid; no backpressure on this port.
- imem_rsp_data  in  32  fetched instruction word.
- instr_valid  out  1  instr and instr_pc hold a valid instruction for decode.
- instr_ready  in  1  decode consumes the instruction this cycle.
- instr  out  32  buffered instruction.
- instr_pc  out  32  address of the buffered instruction.
- branch_taken  in  1  one-cycle redirect pulse.
- branch_pc  in  32  PC of the taken branch.
- imm_ext  in  32  sign-extended B-type immediate; bit 0 is already 0.
- fetch_err  out  1  sticky misaligned-target flag.

## Operation
- States: REQ, WAIT, HOLD, HALT.
- At most one request is outstanding at any time.
- Outputs driven from state: imem_req_valid = (state==REQ); instr_valid = (state==HOLD); fetch_err = (state==HALT).
- REQ:
  - imem_req_addr = pc.
  - On imem_req_valid && imem_req_ready, go to WAIT.
- WAIT:
  - On imem_rsp_valid with discard=0: instr <= imem_rsp_data, instr_pc <= pc, pc <= pc+4, go to HOLD.
  - On imem_rsp_valid with discard=1: drop the data, clear discard, go to REQ.
- HOLD:
  - On instr_valid && instr_ready, go to REQ.
  - instr and instr_pc stay stable while instr_ready=0.
- Redirect:
  - target = branch_pc + imm_ext, 32-bit add, wraps modulo 2^32.
  - When branch_taken=1 and target[1:0]==0, pc <= target. Redirect has priority over every other transition.
  - From REQ without a handshake: stay in REQ. The address changes to target next cycle; this is the only case where the address changes while valid is held.
  - From REQ with a handshake in the same cycle: go to WAIT with discard=1, because the in-flight fetch is for the old PC.
  - From WAIT with no response this cycle: set discard=1, stay in WAIT.
  - From WAIT with a response this cycle: drop the response, go to REQ.
  - From HOLD: flush the buffer (instr_valid drops next cycle), go to REQ, even if instr_ready=1 in the same cycle. That handshake still counts as consumed by decode.
- Misaligned target (branch_taken=1 and target[1:0]!=0): go to HALT; pc is unchanged.
- HALT:
  - No requests; instr_valid=0; all responses ignored.
  - Left only by reset.
- branch_taken in HALT is ignored.

## Timing
- Reset values:
  - pc=RESET_PC, state=REQ, discard=0.
  - instr=0, instr_pc=0.
  - instr_valid=0, fetch_err=0.
  - imem_req_valid=0 while reset is high; it goes to 1 in the first cycle after reset deasserts.
- Reset asserted mid-operation has priority over everything, including any outstanding request. A response for a pre-reset request must not arrive after reset; this is a memory contract.
- Memory contract: a response arrives 1 or more cycles after its request handshake, never in the same cycle.
- Latency:
  - Request handshake in cycle c, response in cycle c+k: instr_valid=1 from cycle c+k+1.
  - With always-ready memory (k=1) and always-ready decode, one instruction completes every 3 cycles.
- Redirect effect: the new imem_req_addr appears the cycle after branch_taken, or after the discarded response returns if the block was in WAIT.

## Test plan
- Reset release, imem_req_ready=1, 1-cycle memory, instr_ready=1 -> requests at 0x0, 0x4, 0x8, each 3 cycles apart; instr_pc matches each request address; fetch_err=0.
- Decode stall: hold instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, imem_req_valid=0; the next request is issued the cycle after instr_ready=1.
- Redirect in HOLD: branch_pc=0x10, imm_ext=0xFFFF_FFF8 -> instr_valid drops, next imem_req_addr=0x8.
- Redirect in WAIT with 3-cycle memory: branch_pc=0x20, imm_ext=0x40 -> the old response is dropped (instr_valid stays 0), next request is to 0x60.
- Redirect in the same cycle as a REQ handshake -> the in-flight response is discarded, the following request carries target.
- Misaligned target: branch_pc=0x4, imm_ext=0x2 -> fetch_err=1 from the next cycle, no further requests; reset clears it and fetch restarts at RESET_PC.
